// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the bridge error-sequencing state type.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ERR1   = 2'd1,
        ERR2   = 2'd2
    } err_state_t;

endpackage

// File: rtl/ahb3lite_master_bridge_if.sv
// Command/response stream plus AHB3-Lite master signals for the bridge.
// cmd: a command transfers on any HCLK edge where cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface ahb3lite_master_bridge_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    import ahb3lite_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [HADDR_SIZE-1:0] cmd_addr;
    logic                  cmd_write;
    logic [2:0]            cmd_size;
    logic [HDATA_SIZE-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [HDATA_SIZE-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [HADDR_SIZE-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb3lite_master_bridge.sv
// AHB3-Lite initiator: command stream to pipelined SINGLE transfers with
// an address slot (A), a data slot (D) and a two-cycle ERROR sequencer.
module ahb3lite_master_bridge
    import ahb3lite_pkg::*;
#(
    parameter int         HADDR_SIZE = 32,
    parameter int         HDATA_SIZE = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    ahb3lite_master_bridge_if.master  bus,
    output err_state_t                state
);

    logic                  a_valid;
    logic                  a_write;
    logic [HADDR_SIZE-1:0] a_addr;
    logic [2:0]            a_size;
    logic [HDATA_SIZE-1:0] a_wdata;
    logic                  d_valid;
    logic                  d_write;
    logic [HDATA_SIZE-1:0] d_wdata;
    logic                  cancelled;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [HDATA_SIZE-1:0] rsp_rdata_q;

    err_state_t state_nxt;
    logic       err_start;
    logic       cmd_ready_c;
    logic       accept;

    assign cmd_ready_c = (state == NORMAL) && (!a_valid || bus.HREADY);
    assign accept      = bus.cmd_valid && cmd_ready_c;

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= NORMAL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_start = 1'b0;
        case (state)
            NORMAL: begin
                if (d_valid && bus.HRESP == HRESP_ERROR && !bus.HREADY) begin
                    state_nxt = ERR1;
                    err_start = 1'b1;
                end
            end
            ERR1:    if (bus.HREADY) state_nxt = ERR2;
            ERR2:    state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid     <= 1'b0;
            a_write     <= 1'b0;
            a_addr      <= '0;
            a_size      <= HSIZE_BYTE;
            a_wdata     <= '0;
            d_valid     <= 1'b0;
            d_write     <= 1'b0;
            d_wdata     <= '0;
            cancelled   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (d_valid && bus.HREADY) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= bus.HRESP;
                if (!d_write && bus.HRESP == HRESP_OKAY) rsp_rdata_q <= bus.HRDATA;
            end else if (state == ERR2 && cancelled) begin
                // The cancelled command answers right behind the error response.
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
            end
            if (state == ERR2) cancelled <= 1'b0;

            if (bus.HREADY) begin
                d_valid <= a_valid;
                if (a_valid) begin
                    d_write <= a_write;
                    d_wdata <= a_wdata;
                end
            end

            // A command accepted on the first error edge is cancelled like one already in A.
            if (err_start) begin
                a_valid <= 1'b0;
                if (a_valid || accept) cancelled <= 1'b1;
            end else if (accept) begin
                a_valid <= 1'b1;
                a_write <= bus.cmd_write;
                a_addr  <= bus.cmd_addr;
                a_size  <= bus.cmd_size;
                a_wdata <= bus.cmd_wdata;
            end else if (bus.HREADY) begin
                a_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.HADDR     = a_addr;
    assign bus.HWRITE    = a_write;
    assign bus.HSIZE     = a_size;
    assign bus.HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWDATA    = d_wdata;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

    // An ERROR response must be preceded by a wait cycle.
    a_err_needs_wait: assert property (@(posedge HCLK) disable iff (HRESET)
        !(state == NORMAL && d_valid && bus.HRESP == HRESP_ERROR && bus.HREADY))
        else $error("ahb3lite_master_bridge: single-cycle ERROR response");

endmodule

// File: doc/ahb3lite_master_bridge.md
Name: ahb3lite_master_bridge

Overview:
AHB3-Lite initiator that turns a simple valid/ready command stream into single, pipelined AHB transfers. It is the bus-master end that drives the memory subsystem's HSEL/HADDR/HTRANS/HWDATA inputs and consumes its HRDATA/HREADYOUT/HRESP. Address and data phases overlap, so a zero-wait slave sustains one transfer per cycle. Every command returns exactly one in-order response, including cancelled ones.

Parameters:
HADDR_SIZE, 32, address width
HDATA_SIZE, 32, data width
HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (non-cacheable, non-bufferable, privileged, data)

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at HCLK edge
cmd_addr  in  HADDR_SIZE  byte address, aligned to cmd_size (caller's duty)
cmd_write  in  1  1=write, 0=read
cmd_size  in  3  HSIZE encoding; 0/1/2 only
cmd_wdata  in  HDATA_SIZE  write data, already lane-aligned
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  HDATA_SIZE  read data (0 for writes and errors)
rsp_err  out  1  1 = slave ERROR or cancelled transfer
HADDR  out  HADDR_SIZE  AHB address
HWRITE  out  1  AHB write
HSIZE  out  3  AHB size
HBURST  out  3  constant 3'b000 (SINGLE)
HPROT  out  4  HPROT_VAL
HTRANS  out  2  IDLE (00) or NONSEQ (10) only
HMASTLOCK  out  1  constant 0
HWDATA  out  HDATA_SIZE  data-phase write data
HRDATA  in  HDATA_SIZE  read data
HREADY  in  1  transfer-complete/phase-advance
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (synchronous): HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; address-phase and data-phase slots empty; state NORMAL. Reset mid-transfer drops all outstanding commands and emits no response for them.
- All AHB outputs are registered.
- Slots: A (address phase) holds {addr, write, size, wdata}; D (data phase) holds {write, wdata}.
- cmd_ready = (state==NORMAL) && (!A.valid || HREADY). On acceptance, A is loaded and HTRANS=NONSEQ on the next cycle. With no acceptance and A advancing, HTRANS returns to IDLE.
- A advances to D at an edge where HREADY=1. HWDATA = D.wdata throughout the data phase. While HREADY=0, A and D hold and all outputs stay stable.
- D completes at an edge where HREADY=1. rsp_valid=1 the next cycle, with rsp_err=HRESP and rsp_rdata=HRDATA for an OKAY read, else 0.
- Latency for a zero-wait slave: accept at edge T0, address phase cycle 1, data phase cycle 2, rsp_valid in cycle 3. Each wait state adds one cycle.
- Error, state machine NORMAL -> ERR1 -> ERR2 -> NORMAL:
  - NORMAL -> ERR1: D.valid, HRESP=1 and HREADY=0 sampled (first error cycle). At that edge, if A holds a NONSEQ, HTRANS is forced to IDLE, A is cleared and marked cancelled.
  - ERR1 -> ERR2: HRESP=1 and HREADY=1 sampled. D completes; rsp_valid=1 with rsp_err=1 in the next cycle.
  - ERR2 -> NORMAL after one cycle. If a command was cancelled, it emits rsp_valid=1, rsp_err=1 in the ERR2 cycle's successor, i.e. back-to-back after the error response.
  - cmd_ready=0 in ERR1 and ERR2.
- HRESP=1 with HREADY=1 while state=NORMAL is a protocol violation: flagged by assertion; treated as an error completion without cancel.
- Response emission and new command acceptance in the same cycle are independent and both allowed.
- At most 2 commands are outstanding (A and D); responses are strictly in command order.

Decomposition:
- Shared package ahb3lite_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HALF/WORD
  - HBURST_SINGLE
  - HRESP_OKAY/ERROR
  - the err_state_t enum {NORMAL, ERR1, ERR2}
- Single module, no sub-module. Slot registers and the error FSM live in one file.

Test Plan:
1. Write 0x0000_0010 = 0xDEADBEEF, then read 0x0000_0010, zero-wait slave -> HTRANS NONSEQ in consecutive cycles; HWDATA=0xDEADBEEF in the read's address cycle; rsp pulses in cycles 3 and 4 with the read rsp_rdata=0xDEADBEEF, rsp_err=0.
2. 8 back-to-back reads, cmd_valid held high -> cmd_ready stays 1 and 8 consecutive rsp_valid pulses occur with no IDLE gaps on HTRANS.
3. Slave inserts 2 wait states on a read -> HADDR/HTRANS/HWDATA stable for 3 cycles, cmd_ready=0 while A is full, rsp_valid 2 cycles later than in scenario 1.
4. Read to unmapped 0x2000_0000 with the slave giving two-cycle ERROR while a write to 0x0000_0004 is in A -> HTRANS becomes IDLE in the second error cycle; two responses occur, both rsp_err=1; the write never appears as NONSEQ.
5. HRESET asserted for one cycle while a read is in the data phase and HREADY=0 -> next cycle HTRANS=IDLE, rsp_valid stays 0, cmd_ready=1.
6. Byte write cmd_size=0 at 0x0000_0003 -> HSIZE=3'b000, HADDR=0x0000_0003, HBURST=000, HPROT=0011, HMASTLOCK=0.
